// File: rtl/risc_int_ctrl.sv
// -----------------------------------------------------------------------------
// risc_int_ctrl
//
// Prioritised, maskable interrupt controller for the RISC core. Rising edges on
// the irq lines are latched into a pending register; pending sources that are
// not masked are arbitrated with fixed priority (lowest index wins), and one
// request at a time is offered to the core through a request / acknowledge /
// return handshake together with the handler address of the chosen source.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst         asynchronous active-low reset
//   irq         interrupt lines, synchronous to clk, rising edge significant
//   mask_we     write strobe for the mask register
//   mask_wdata  new mask value, bit=1 masks the source
//   int_ack     core accepts the current request
//   iret        core has finished the handler
//   int_req     interrupt request to the core
//   int_id      index of the requested / serviced source
//   int_vec     handler address for int_id
//   busy        a handler is in service
//   pending     pending-event register (read-only view)
// -----------------------------------------------------------------------------
module risc_int_ctrl #(
    parameter int          NSRC       = 4,
    parameter int          ID_W       = 2,
    parameter logic [15:0] VEC_BASE   = 16'h0100,
    parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            int_ack,
    input  logic            iret,
    output logic            int_req,
    output logic [ID_W-1:0] int_id,
    output logic [15:0]     int_vec,
    output logic            busy,
    output logic [NSRC-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    // Lowest set index of v; v is known non-zero whenever the result is used.
    function automatic logic [ID_W-1:0] prio_enc(input logic [NSRC-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            r = v[i] ? ID_W'(i) : r;
        end
        return r;
    endfunction

    // Handler address of a source, wrapping modulo 2^16.
    function automatic logic [15:0] vec_of(input logic [ID_W-1:0] id);
        return VEC_BASE + (16'(id) * VEC_STRIDE);
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [NSRC-1:0] irq_q_r;
    logic [NSRC-1:0] pending_r;
    logic [NSRC-1:0] mask_r;
    logic            int_req_r;
    logic            busy_r;
    logic [ID_W-1:0] int_id_r;
    logic [15:0]     int_vec_r;

    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] eligible_s;
    logic [NSRC-1:0] clr_s;
    logic [ID_W-1:0] winner_s;
    logic            ack_s;
    logic            withdraw_s;

    logic            int_req_nxt_s;
    logic            busy_nxt_s;
    logic [ID_W-1:0] int_id_nxt_s;
    logic [15:0]     int_vec_nxt_s;

    // Edge detection, arbitration and handshake qualifiers.
    always_comb begin
        rise_s     = irq & ~irq_q_r;
        eligible_s = pending_r & ~mask_r;
        winner_s   = prio_enc(eligible_s);
        ack_s      = (state_r == ST_REQ) && int_ack;
        // Withdraw looks at the registered mask, so a write lands one edge
        // later; a simultaneous acknowledge always wins.
        withdraw_s = (state_r == ST_REQ) && !int_ack && mask_r[int_id_r];
        if (ack_s) begin
            clr_s = {{(NSRC-1){1'b0}}, 1'b1} << int_id_r;
        end else begin
            clr_s = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (eligible_s != '0) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_nxt_s = ST_SERV;
                end else if (withdraw_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_SERV: begin
                if (iret) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERV;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; id/vec only change on capture.
    always_comb begin
        int_req_nxt_s = int_req_r;
        busy_nxt_s    = busy_r;
        int_id_nxt_s  = int_id_r;
        int_vec_nxt_s = int_vec_r;
        case (state_r)
            ST_IDLE: begin
                if (eligible_s != '0) begin
                    int_req_nxt_s = 1'b1;
                    int_id_nxt_s  = winner_s;
                    int_vec_nxt_s = vec_of(winner_s);
                end else begin
                    int_req_nxt_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    int_req_nxt_s = 1'b0;
                    busy_nxt_s    = 1'b1;
                end else if (withdraw_s) begin
                    int_req_nxt_s = 1'b0;
                end else begin
                    int_req_nxt_s = 1'b1;
                end
            end
            ST_SERV: begin
                if (iret) begin
                    busy_nxt_s = 1'b0;
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                int_req_nxt_s = 1'b0;
                busy_nxt_s    = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_req_r <= 1'b0;
            busy_r    <= 1'b0;
            int_id_r  <= '0;
            int_vec_r <= 16'h0000;
        end else begin
            int_req_r <= int_req_nxt_s;
            busy_r    <= busy_nxt_s;
            int_id_r  <= int_id_nxt_s;
            int_vec_r <= int_vec_nxt_s;
        end
    end

    // irq delay, pending and mask registers. The delay register resets to
    // zero so a line already high at reset release registers as one edge.
    // A new edge on the acknowledged source in the same cycle keeps it pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q_r   <= '0;
            pending_r <= '0;
            mask_r    <= '1;
        end else begin
            irq_q_r   <= irq;
            pending_r <= (pending_r & ~clr_s) | rise_s;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign int_req = int_req_r;
    assign busy    = busy_r;
    assign int_id  = int_id_r;
    assign int_vec = int_vec_r;
    assign pending = pending_r;

endmodule

// File: tb/tb_risc_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_risc_int_ctrl
//
// Directed bench for risc_int_ctrl. Expected request id/vector pairs are pushed
// into a scoreboard queue when the triggering irq edges are driven and popped
// when the controller raises int_req. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_risc_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        int_ack;
    logic        iret;
    logic        int_req;
    logic [1:0]  int_id;
    logic [15:0] int_vec;
    logic        busy;
    logic [3:0]  pending;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fails;

    risc_int_ctrl #(
        .NSRC(4), .ID_W(2), .VEC_BASE(16'h0100), .VEC_STRIDE(16'h0010)
    ) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .int_ack(int_ack), .iret(iret),
        .int_req(int_req), .int_id(int_id), .int_vec(int_vec),
        .busy(busy), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        sb.push_back(e);
    endtask

    // Compare the request currently presented against the scoreboard head.
    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $error("FAIL %s_sb_empty observed=request expected=none", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_req"}, 32'(int_req), 32'd1);
            check({tag, "_id"},  32'(int_id),  32'(e.id));
            check({tag, "_vec"}, 32'(int_vec), 32'(e.vec));
        end
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && int_req !== 1'b1; i++) tick();
        check({tag, "_wait"}, 32'(int_req), 32'd1);
    endtask

    task automatic ack_and_ret();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        iret    = 1'b1; tick(); iret    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b0; irq = 4'b0000; mask_we = 1'b0; mask_wdata = 4'b0000;
        int_ack = 1'b0; iret = 1'b0;
        tick(); tick();
        check("rst_req",  32'(int_req), 32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_id",   32'(int_id),  32'd0);
        check("rst_vec",  32'(int_vec), 32'h0);
        check("rst_pend", 32'(pending), 32'h0);
        rst = 1'b1;
        tick();

        // Single source, two-cycle latency, full handshake.
        mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
        push(2'd2, 16'h0120);
        irq = 4'b0100; tick(); irq = 4'b0000;
        check("t1_pend_set", 32'(pending), 32'h4);
        check("t1_req_lat1", 32'(int_req), 32'd0);
        tick();
        pop_cmp("t1");
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check("t1_ack_req",  32'(int_req), 32'd0);
        check("t1_ack_busy", 32'(busy),    32'd1);
        check("t1_ack_pend", 32'(pending), 32'h0);
        iret = 1'b1; tick(); iret = 1'b0;
        check("t1_ret_busy", 32'(busy),   32'd0);
        check("t1_hold_id",  32'(int_id), 32'd2);

        // Simultaneous sources 3 and 1: priority, then one idle cycle.
        push(2'd1, 16'h0110);
        push(2'd3, 16'h0130);
        irq = 4'b1010; tick(); irq = 4'b0000;
        tick();
        pop_cmp("t2a");
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check("t2_pend", 32'(pending), 32'h8);
        iret = 1'b1; tick(); iret = 1'b0;
        check("t2_idle_gap", 32'(int_req), 32'd0);
        tick();
        pop_cmp("t2b");
        ack_and_ret();

        // Masked source latches pending; unmasking releases it one edge later.
        mask_we = 1'b1; mask_wdata = 4'b0001; tick(); mask_we = 1'b0;
        irq = 4'b0001; tick(); irq = 4'b0000;
        tick(); tick();
        check("t3_pend", 32'(pending), 32'h1);
        check("t3_noreq", 32'(int_req), 32'd0);
        push(2'd0, 16'h0100);
        mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
        check("t3_mask_lag", 32'(int_req), 32'd0);
        wait_req("t3", 4);
        pop_cmp("t3");
        ack_and_ret();

        // No nesting; edge coinciding with its own ack stays pending.
        push(2'd1, 16'h0110);
        irq = 4'b0010; tick(); irq = 4'b0000;
        wait_req("t4a", 4);
        pop_cmp("t4a");
        int_ack = 1'b1; irq = 4'b0010; tick(); int_ack = 1'b0; irq = 4'b0000;
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_set_wins", 32'(pending), 32'h2);
        irq = 4'b0001; tick(); irq = 4'b0000;
        tick(); tick();
        check("t4_nonest_req", 32'(int_req), 32'd0);
        check("t4_pend2", 32'(pending), 32'h3);
        push(2'd0, 16'h0100);
        push(2'd1, 16'h0110);
        iret = 1'b1; tick(); iret = 1'b0;
        check("t4_ret_busy", 32'(busy), 32'd0);
        wait_req("t4b", 4);
        pop_cmp("t4b");
        ack_and_ret();
        wait_req("t4c", 4);
        pop_cmp("t4c");
        ack_and_ret();

        // Withdraw on mask of the requested source.
        irq = 4'b0100; tick(); irq = 4'b0000;
        wait_req("t5", 4);
        check("t5_id", 32'(int_id), 32'd2);
        mask_we = 1'b1; mask_wdata = 4'b0100; tick(); mask_we = 1'b0;
        check("t5_req_still", 32'(int_req), 32'd1);
        tick();
        check("t5_withdraw", 32'(int_req), 32'd0);
        check("t5_pend_kept", 32'(pending), 32'h4);
        check("t5_busy", 32'(busy), 32'd0);
        push(2'd2, 16'h0120);
        mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
        wait_req("t5b", 4);
        pop_cmp("t5b");

        // Asynchronous reset in REQ.
        rst = 1'b0;
        #1;
        check("t6_req",  32'(int_req), 32'd0);
        check("t6_busy", 32'(busy),    32'd0);
        check("t6_pend", 32'(pending), 32'h0);
        check("t6_id",   32'(int_id),  32'd0);
        check("t6_vec",  32'(int_vec), 32'h0);
        irq = 4'b1000;
        tick();
        rst = 1'b1;
        tick();
        check("t6_high_at_release", 32'(pending), 32'h8);
        irq = 4'b0001; tick(); irq = 4'b0000;
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check("t6_mask_ones_pend", 32'(pending), 32'h9);
        check("t6_mask_ones_req",  32'(int_req), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/risc_int_ctrl.md
# risc_int_ctrl

Prioritised, maskable interrupt controller for the RISC core. It latches rising edges on up to NSRC external interrupt lines and arbitrates among pending, unmasked sources with fixed priority. It presents one request at a time to the core, with a handler vector, through a request/acknowledge/return handshake. It sits between board-level interrupt sources (including the top-level INT line on source 0) and the core's fetch/PC-redirect logic.

## Interface
- NSRC, 4: number of interrupt sources, 2..16
- ID_W, 2: width of source index, equals clog2(NSRC)
- VEC_BASE, 16'h0100: handler address of source 0
- VEC_STRIDE, 16'h0010: address spacing between handlers

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- irq  in  NSRC  interrupt lines, synchronous to clk, rising-edge significant
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  NSRC  new mask value; bit=1 masks the source
- int_ack  in  1  core accepts the current request (at an instruction boundary)
- iret  in  1  core has finished the handler (return-from-interrupt)
- int_req  out  1  interrupt request to core
- int_id  out  ID_W  index of the requested/serviced source
- int_vec  out  16  handler address for int_id
- busy  out  1  a handler is in service
- pending  out  NSRC  pending-event register (read-only view)

## Operation
- Reset (rst=0): state IDLE, int_req=0, busy=0, int_id=0, int_vec=0, pending=0, mask all ones, irq delay register=0.
  - A line already high at reset release counts as one edge.
- Edge detect: rise[i] = irq[i] & ~irq_q[i]; irq_q <= irq every cycle.
- pending[i] is set on rise[i]. It is cleared only when source i is acknowledged.
  - If set and clear hit the same cycle, set wins.
  - Masked sources still latch pending. Masking only blocks arbitration.
- Mask register loads mask_wdata when mask_we=1.
- Eligible = pending & ~mask. Priority is fixed: lowest index wins.
- FSM states:
  - IDLE: if eligible≠0, capture winner into int_id, set int_vec = VEC_BASE + int_id*VEC_STRIDE (mod 2^16), set int_req=1, go to REQ.
  - REQ: int_req=1; int_id and int_vec are frozen and a higher-priority arrival does not replace them.
    - int_ack=1: clear pending[int_id], int_req=0, busy=1, go to SERV.
    - Otherwise, if mask[int_id] becomes 1 (register value), withdraw the request: int_req=0, go to IDLE, pending kept.
    - int_ack takes precedence over withdraw in the same cycle.
  - SERV: busy=1, no nesting. New edges still latch pending. On iret=1: busy=0, go to IDLE.
- int_ack outside REQ is ignored; iret outside SERV is ignored.
- int_id and int_vec hold their last value in IDLE and SERV.
- A mask_we that coincides with int_ack has no effect on the acknowledge.
- rst asserted mid-operation immediately returns all state to reset values. Any in-flight request is lost.

## Timing
- All outputs are registered.
- irq rising, sampled at edge k: pending set after k.
- At edge k+1 (IDLE, unmasked): int_req=1 with valid int_id/int_vec. Latency from irq to int_req is 2 cycles.
- int_ack sampled at edge m: after m, int_req=0, busy=1, pending bit clear.
- iret sampled at edge n: after n, busy=0. The next eligible source raises int_req after n+1, giving a minimum of 1 idle cycle between services.
- Mask write at edge w: takes effect for arbitration at edge w+1.

## Test plan
- Reset, then mask_wdata=4'b0000, pulse irq[2] -> int_req=1 two cycles after the edge, int_id=2, int_vec=16'h0120; int_ack -> int_req=0, busy=1, pending=0; iret -> busy=0.
- irq[3] and irq[1] rise in the same cycle -> int_id=1 first (vec 16'h0110); after ack/iret, int_id=3 (vec 16'h0130) one cycle after IDLE.
- mask=4'b0001, pulse irq[0] -> pending=4'b0001, int_req stays 0; write mask=0 -> int_req=1, int_id=0, int_vec=16'h0100.
- In SERV on source 1, pulse irq[0] -> no int_req until iret. Then source 0 is serviced. A second irq[1] edge in the same cycle as its ack leaves pending[1]=1.
- In REQ for source 2, set mask bit 2 -> int_req drops next cycle, pending[2] stays 1.
- Assert rst mid-REQ -> int_req=0, busy=0, pending=0, mask=4'b1111 immediately.
